mod_signal_monitor: RTL
=======================

Name: mod_signal_monitor

Overview:
- Receive-side checker for the three modulated imager clocks (CLK, CLKN, CLKL) driven to the MB imager board.
- Samples the three signals in the USER_CLOCK domain and measures CLK period, CLK high time and CLK-to-CLKL phase delay, each averaged over 2^AVG_LOG2 periods.
- Flags CLK/CLKN overlap, missing CLKL edges and timeouts.
- Sits beside the signal generator and reports to the OK board host, so FREQ_SEL/PHASE_SEL/DUTY_SEL settings can be confirmed in hardware.

Parameters:
- CNT_W, 16, width of per-period cycle counters and result outputs.
- AVG_LOG2, 2, log2 of the number of CLK periods accumulated per measurement (1..4).
- TIMEOUT_CYC, 65535, USER_CLOCK cycles allowed between CLK rising edges before abort; must be <= 2^CNT_W-1.

Ports:
- USER_CLOCK  in  1  system clock; all logic runs on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse; begins a measurement.
- MBI_CLK_MOD  in  1  modulated CLK, asynchronous to USER_CLOCK.
- MBI_CLKN_MOD  in  1  modulated CLKN, asynchronous.
- MBI_CLKL_MOD  in  1  modulated CLKL, asynchronous.
- BUSY  out  1  high from START acceptance until DONE or ERR.
- VALID  out  1  results valid; held until the next accepted START.
- PERIOD_CNT  out  CNT_W  averaged CLK period in USER_CLOCK cycles.
- HIGH_CNT  out  CNT_W  averaged CLK high time.
- PHASE_CNT  out  CNT_W  averaged delay, CLK rise to CLKL rise.
- OVERLAP_ERR  out  1  sticky: CLK and CLKN were high together during measurement.
- CLKL_MISS_ERR  out  1  sticky: a CLK period contained no CLKL rise.
- TIMEOUT_ERR  out  1  sticky: no CLK rise within TIMEOUT_CYC cycles.

Behaviour:
- Reset (RESET_N=0, asynchronous): all outputs 0, state IDLE, synchronizers and accumulators cleared.
- Input conditioning:
  - Each input passes a 2-FF synchronizer.
  - Rise/fall are detected on the synchronized value against a third registered copy.
  - Total input-to-edge-strobe latency is 3 cycles, identical for all three inputs, so relative timing is preserved.
- State machine:
  - IDLE: START=1 -> ARM. Clears VALID, all errors, all accumulators and the period index. BUSY=1.
  - ARM: waits for the first CLK rise -> MEASURE, starting all counters at 0. If the timeout counter reaches TIMEOUT_CYC first -> ERR.
  - MEASURE:
    - Period counter increments every cycle and restarts at 1 on each CLK rise.
    - High counter increments while synchronized CLK=1.
    - Phase counter runs from CLK rise until the first CLKL rise, then freezes.
    - On each CLK rise, add period/high/phase into accumulators of width CNT_W+AVG_LOG2 and increment the period index.
    - When the index reaches 2^AVG_LOG2 -> DONE.
    - Timeout counter resets on every CLK rise; reaching TIMEOUT_CYC -> ERR.
  - DONE (1 cycle): latch each result as accumulator >> AVG_LOG2 (truncated), set VALID=1, clear BUSY -> IDLE.
  - ERR (1 cycle): set TIMEOUT_ERR, clear BUSY, leave VALID=0 and results unchanged -> IDLE.
- START while BUSY is ignored. START in the same cycle as DONE is ignored.
- Boundary and simultaneity rules:
  - CLK rise and CLKL rise in the same cycle: phase sample = 0.
  - No CLKL rise within a period: phase sample = 0 and CLKL_MISS_ERR set; measurement still completes.
  - Only the first CLKL rise per period counts.
  - OVERLAP_ERR sets in any MEASURE cycle with synchronized CLK=1 and CLKN=1.
  - Period counter saturates at 2^CNT_W-1. Saturation is unreachable when TIMEOUT_CYC is within range.
  - Static CLK (FREQ_SEL pointing to an unused output): ends in ERR after TIMEOUT_CYC cycles.
- The block is undefined for CLK faster than USER_CLOCK/4 (e.g. 50 MHz on the high-freq build). Results for such inputs are "don't care" but the FSM must still terminate via DONE or ERR.

Optional Feature:
- MON_GLITCH_FILTER_EN
- Defined: an edge is recognized only after the synchronized level has been stable for 2 consecutive cycles. This rejects 1-cycle glitches and adds 1 cycle of latency, equally to all inputs, so no measured value changes for clean signals.
- Undefined: no filter; a 1-cycle pulse produces an edge.

Test Plan:
- USER_CLOCK 100 MHz, CLK 1 MHz at 50% duty, CLKN its inverse with 20 ns dead time, CLKL delayed 250 ns, AVG_LOG2=2, START -> after about 5 periods VALID=1, PERIOD_CNT=100, HIGH_CNT=50, PHASE_CNT=25, no errors.
- Same setup, CLKN overlapping CLK by 30 ns each edge -> VALID=1, OVERLAP_ERR=1, PERIOD_CNT=100.
- CLKL held low -> VALID=1, PHASE_CNT=0, CLKL_MISS_ERR=1.
- CLK held low, TIMEOUT_CYC=1000 -> BUSY drops 1001±1 cycles after START, TIMEOUT_ERR=1, VALID=0.
- RESET_N pulsed low mid-MEASURE, then a new START with 100 kHz CLK at 25% duty -> all outputs 0 during reset; afterwards PERIOD_CNT=1000, HIGH_CNT=250.
- With MON_GLITCH_FILTER_EN, a 10 ns glitch on CLK mid-low-phase -> PERIOD_CNT=100 unchanged. Without the macro, the same glitch gives a corrupted PERIOD_CNT below 100.

Source files
------------

// File: rtl/mod_signal_monitor.sv
// mod_signal_monitor: averaged CLK period, CLK high time and CLK->CLKL phase of the modulated imager clocks.
// Define MON_GLITCH_FILTER_EN to reject input pulses shorter than two USER_CLOCK cycles.
module mod_signal_monitor #(
    parameter int CNT_W       = 16,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             USER_CLOCK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             MBI_CLK_MOD,
    input  logic             MBI_CLKN_MOD,
    input  logic             MBI_CLKL_MOD,
    output logic             BUSY,
    output logic             VALID,
    output logic [CNT_W-1:0] PERIOD_CNT,
    output logic [CNT_W-1:0] HIGH_CNT,
    output logic [CNT_W-1:0] PHASE_CNT,
    output logic             OVERLAP_ERR,
    output logic             CLKL_MISS_ERR,
    output logic             TIMEOUT_ERR
);
    localparam int AW = CNT_W + AVG_LOG2;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [2:0] S_IDLE = 3'd0, S_ARM = 3'd1, S_MEAS = 3'd2, S_DONE = 3'd3, S_ERR = 3'd4;

    // bit 0 = CLK, bit 1 = CLKN, bit 2 = CLKL
    logic [2:0] s1_q, s2_q, lvl;
    logic       r_clk, r_clkl;

    always_ff @(posedge USER_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= {MBI_CLKL_MOD, MBI_CLKN_MOD, MBI_CLK_MOD};
            s2_q <= s1_q;
        end
    end

`ifdef MON_GLITCH_FILTER_EN
    logic [2:0] s3_q, f_q;
    // filtered level only follows the input once two consecutive samples agree
    assign lvl    = (s2_q & s3_q) | (f_q & (s2_q | s3_q));
    assign r_clk  = lvl[0] & ~f_q[0];
    assign r_clkl = lvl[2] & ~f_q[2];
    always_ff @(posedge USER_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            s3_q <= '0;
            f_q  <= '0;
        end else begin
            s3_q <= s2_q;
            f_q  <= lvl;
        end
    end
`else
    logic [1:0] s3_q;
    assign lvl    = s2_q;
    assign r_clk  = lvl[0] & ~s3_q[0];
    assign r_clkl = lvl[2] & ~s3_q[1];
    always_ff @(posedge USER_CLOCK or negedge RESET_N) begin
        if (!RESET_N) s3_q <= '0;
        else          s3_q <= {s2_q[2], s2_q[0]};
    end
`endif

    logic [2:0]          state_q, state_d;
    logic                busy_q, busy_d, valid_q, valid_d, hit_q, hit_d;
    logic                ovl_q, ovl_d, miss_q, miss_d, terr_q, terr_d;
    logic [CNT_W-1:0]    per_q, per_d, high_q, high_d, ph_q, ph_d, tmo_q, tmo_d;
    logic [CNT_W-1:0]    per_o_q, per_o_d, high_o_q, high_o_d, ph_o_q, ph_o_d;
    logic [AVG_LOG2-1:0] idx_q, idx_d;
    logic [AW-1:0]       acc_p_q, acc_p_d, acc_h_q, acc_h_d, acc_ph_q, acc_ph_d;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        hit_d    = hit_q;
        ovl_d    = ovl_q;
        miss_d   = miss_q;
        terr_d   = terr_q;
        per_d    = per_q;
        high_d   = high_q;
        ph_d     = ph_q;
        tmo_d    = tmo_q;
        idx_d    = idx_q;
        acc_p_d  = acc_p_q;
        acc_h_d  = acc_h_q;
        acc_ph_d = acc_ph_q;
        per_o_d  = per_o_q;
        high_o_d = high_o_q;
        ph_o_d   = ph_o_q;
        case (state_q)
            S_IDLE: if (START) begin
                state_d  = S_ARM;
                busy_d   = 1'b1;
                valid_d  = 1'b0;
                hit_d    = 1'b0;
                ovl_d    = 1'b0;
                miss_d   = 1'b0;
                terr_d   = 1'b0;
                per_d    = '0;
                high_d   = '0;
                ph_d     = '0;
                tmo_d    = '0;
                idx_d    = '0;
                acc_p_d  = '0;
                acc_h_d  = '0;
                acc_ph_d = '0;
            end
            S_ARM, S_MEAS: begin
                tmo_d = tmo_q + ONE;
                if (state_q == S_MEAS) begin
                    per_d  = (per_q == '1) ? per_q : per_q + ONE;
                    high_d = high_q + CNT_W'(lvl[0]);
                    ph_d   = hit_q ? ph_q : ph_q + ONE;
                    hit_d  = hit_q | r_clkl;
                    ovl_d  = ovl_q | (lvl[0] & lvl[1]);
                end
                if (r_clk) begin
                    // a rise closes the previous period and opens a new one in this same cycle
                    if (state_q == S_MEAS) begin
                        acc_p_d  = acc_p_q + AW'(per_q);
                        acc_h_d  = acc_h_q + AW'(high_q);
                        acc_ph_d = acc_ph_q + (hit_q ? AW'(ph_q) : '0);
                        miss_d   = miss_q | ~hit_q;
                        idx_d    = idx_q + AVG_LOG2'(1);
                    end
                    state_d = (state_q == S_MEAS && idx_q == '1) ? S_DONE : S_MEAS;
                    tmo_d   = '0;
                    per_d   = ONE;
                    high_d  = ONE;
                    ph_d    = '0;
                    hit_d   = r_clkl;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                busy_d   = 1'b0;
                valid_d  = 1'b1;
                per_o_d  = acc_p_q[AW-1:AVG_LOG2];
                high_o_d = acc_h_q[AW-1:AVG_LOG2];
                ph_o_d   = acc_ph_q[AW-1:AVG_LOG2];
            end
            S_ERR: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                terr_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge USER_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            hit_q    <= 1'b0;
            ovl_q    <= 1'b0;
            miss_q   <= 1'b0;
            terr_q   <= 1'b0;
            per_q    <= '0;
            high_q   <= '0;
            ph_q     <= '0;
            tmo_q    <= '0;
            idx_q    <= '0;
            acc_p_q  <= '0;
            acc_h_q  <= '0;
            acc_ph_q <= '0;
            per_o_q  <= '0;
            high_o_q <= '0;
            ph_o_q   <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            hit_q    <= hit_d;
            ovl_q    <= ovl_d;
            miss_q   <= miss_d;
            terr_q   <= terr_d;
            per_q    <= per_d;
            high_q   <= high_d;
            ph_q     <= ph_d;
            tmo_q    <= tmo_d;
            idx_q    <= idx_d;
            acc_p_q  <= acc_p_d;
            acc_h_q  <= acc_h_d;
            acc_ph_q <= acc_ph_d;
            per_o_q  <= per_o_d;
            high_o_q <= high_o_d;
            ph_o_q   <= ph_o_d;
        end
    end

    assign BUSY          = busy_q;
    assign VALID         = valid_q;
    assign PERIOD_CNT    = per_o_q;
    assign HIGH_CNT      = high_o_q;
    assign PHASE_CNT     = ph_o_q;
    assign OVERLAP_ERR   = ovl_q;
    assign CLKL_MISS_ERR = miss_q;
    assign TIMEOUT_ERR   = terr_q;
endmodule
